// File: rtl/pipeline_pkg.sv
// Shared pipeline types: register-file geometry and hazard FSM states.
// Also provides a one-hot register mask helper that never selects x0.
package pipeline_pkg;

    localparam int REG_COUNT  = 32;
    localparam int REG_ADDR_W = 5;

    typedef enum logic {
        HZ_RUN,
        HZ_FLUSH
    } hazard_state;

    // x0 is hardwired to zero, so it never gets a mask bit.
    function automatic logic [REG_COUNT-1:0] reg_mask(
        input logic [REG_ADDR_W-1:0] addr
    );
        reg_mask = '0;
        if (addr != '0) begin
            reg_mask[addr] = 1'b1;
        end
    endfunction

endpackage

// File: rtl/hazard_ctrl_scoreboard.sv
// Register scoreboard: one pending bit per architectural register.
// Ports: clk_i/n_rst, set_en/set_addr, clr_en/clr_addr, pend (registered).
module hazard_ctrl_scoreboard
    import pipeline_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  n_rst,
    input  logic                  set_en,
    input  logic [REG_ADDR_W-1:0] set_addr,
    input  logic                  clr_en,
    input  logic [REG_ADDR_W-1:0] clr_addr,
    output logic [REG_COUNT-1:0]  pend
);

    logic [REG_COUNT-1:0] pend_q;
    logic [REG_COUNT-1:0] set_m;
    logic [REG_COUNT-1:0] clr_m;

    assign set_m = set_en ? reg_mask(set_addr) : '0;
    assign clr_m = clr_en ? reg_mask(clr_addr) : '0;

    // Set is applied after clear so a new writer wins over a retiring one.
    always_ff @(posedge clk_i or negedge n_rst) begin
        if (!n_rst) begin
            pend_q <= '0;
        end else begin
            pend_q <= (pend_q & ~clr_m) | set_m;
        end
    end

    assign pend = pend_q;

endmodule

// File: rtl/hazard_ctrl.sv
// In-order issue controller: RAW/WAW stalls, redirect flush, perf counters.
// Ports: decode operands, ex_ready, writeback retire, redirect -> issue/stall/kill.
module hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 32
) (
    input  logic                  clk_i,
    input  logic                  n_rst,
    input  logic                  id_valid_i,
    input  logic [REG_ADDR_W-1:0] id_rs1_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_i,
    input  logic [REG_ADDR_W-1:0] id_rd_i,
    input  logic                  id_rs1_used_i,
    input  logic                  id_rs2_used_i,
    input  logic                  id_wb_en_i,
    input  logic                  ex_ready_i,
    input  logic                  wb_valid_i,
    input  logic [REG_ADDR_W-1:0] wb_rd_i,
    input  logic                  redirect_i,
    output logic                  issue_o,
    output logic                  stall_o,
    output logic                  kill_o,
    output logic [REG_COUNT-1:0]  busy_regs_o,
    output logic [CNT_W-1:0]      stall_cycles_o,
    output logic [CNT_W-1:0]      flush_count_o
);

    localparam int FC_W = 4;

    hazard_state          state_q;
    hazard_state          state_n;
    logic [FC_W-1:0]      cnt_q;
    logic [FC_W-1:0]      cnt_n;
    logic [REG_COUNT-1:0] pend;
    logic                 raw;
    logic                 waw;
    logic                 issue;
    logic                 stall;
    logic                 kill;
    logic                 redir_acc;
    logic [CNT_W-1:0]     stall_q;
    logic [CNT_W-1:0]     flush_q;

    hazard_ctrl_scoreboard u_sb (
        .clk_i    (clk_i),
        .n_rst    (n_rst),
        .set_en   (issue_o && id_wb_en_i),
        .set_addr (id_rd_i),
        .clr_en   (wb_valid_i),
        .clr_addr (wb_rd_i),
        .pend     (pend)
    );

    // Only the registered scoreboard is consulted; a same-cycle
    // writeback is seen one cycle later.
    assign raw = (id_rs1_used_i && id_rs1_i != '0 && pend[id_rs1_i])
              || (id_rs2_used_i && id_rs2_i != '0 && pend[id_rs2_i]);
    assign waw = id_wb_en_i && id_rd_i != '0 && pend[id_rd_i];

    always_comb begin
        state_n   = state_q;
        cnt_n     = cnt_q;
        issue     = 1'b0;
        stall     = 1'b0;
        kill      = 1'b0;
        redir_acc = 1'b0;
        unique case (state_q)
            HZ_RUN: begin
                kill  = redirect_i;
                issue = id_valid_i && !raw && !waw
                     && ex_ready_i && !redirect_i;
                stall = id_valid_i && !issue && !redirect_i;
                if (redirect_i) begin
                    redir_acc = 1'b1;
                    // Redirect cycle already counts as one kill cycle.
                    if (FLUSH_CYCLES > 1) begin
                        state_n = HZ_FLUSH;
                        cnt_n   = FC_W'(FLUSH_CYCLES - 1);
                    end
                end
            end
            HZ_FLUSH: begin
                kill = 1'b1;
                if (cnt_q <= FC_W'(1)) begin
                    state_n = HZ_RUN;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt_q - FC_W'(1);
                end
            end
            default: begin
                state_n = HZ_RUN;
                cnt_n   = '0;
            end
        endcase
    end

    // Outputs are forced low while reset is held, independent of the clock.
    assign issue_o     = n_rst && issue;
    assign stall_o     = n_rst && stall;
    assign kill_o      = n_rst && kill;
    assign busy_regs_o = pend;

    always_ff @(posedge clk_i or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= HZ_RUN;
            cnt_q   <= '0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            if (stall_o && stall_q != '1) begin
                stall_q <= stall_q + CNT_W'(1);
            end
            if (redir_acc && flush_q != '1) begin
                flush_q <= flush_q + CNT_W'(1);
            end
        end
    end

    assign stall_cycles_o = stall_q;
    assign flush_count_o  = flush_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: vector table through an expectation queue,
// plus reset and counter sequences; a narrow-counter copy checks saturation.
module tb_hazard_ctrl;

    logic        clk_i = 1'b0;
    logic        n_rst;
    logic        id_valid_i;
    logic [4:0]  id_rs1_i;
    logic [4:0]  id_rs2_i;
    logic [4:0]  id_rd_i;
    logic        id_rs1_used_i;
    logic        id_rs2_used_i;
    logic        id_wb_en_i;
    logic        ex_ready_i;
    logic        wb_valid_i;
    logic [4:0]  wb_rd_i;
    logic        redirect_i;
    logic        issue_o;
    logic        stall_o;
    logic        kill_o;
    logic [31:0] busy_regs_o;
    logic [31:0] stall_cycles_o;
    logic [31:0] flush_count_o;
    logic        s_issue;
    logic        s_stall;
    logic        s_kill;
    logic [31:0] s_busy;
    logic [1:0]  s_stall_cnt;
    logic [1:0]  s_flush_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(32)) dut (
        .clk_i(clk_i), .n_rst(n_rst), .id_valid_i(id_valid_i),
        .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_rd_i(id_rd_i),
        .id_rs1_used_i(id_rs1_used_i), .id_rs2_used_i(id_rs2_used_i),
        .id_wb_en_i(id_wb_en_i), .ex_ready_i(ex_ready_i),
        .wb_valid_i(wb_valid_i), .wb_rd_i(wb_rd_i),
        .redirect_i(redirect_i), .issue_o(issue_o), .stall_o(stall_o),
        .kill_o(kill_o), .busy_regs_o(busy_regs_o),
        .stall_cycles_o(stall_cycles_o), .flush_count_o(flush_count_o)
    );

    hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(2)) dut_sat (
        .clk_i(clk_i), .n_rst(n_rst), .id_valid_i(id_valid_i),
        .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_rd_i(id_rd_i),
        .id_rs1_used_i(id_rs1_used_i), .id_rs2_used_i(id_rs2_used_i),
        .id_wb_en_i(id_wb_en_i), .ex_ready_i(ex_ready_i),
        .wb_valid_i(wb_valid_i), .wb_rd_i(wb_rd_i),
        .redirect_i(redirect_i), .issue_o(s_issue), .stall_o(s_stall),
        .kill_o(s_kill), .busy_regs_o(s_busy),
        .stall_cycles_o(s_stall_cnt), .flush_count_o(s_flush_cnt)
    );

    typedef struct {
        logic       valid;
        logic [4:0] rs1;
        logic       u1;
        logic [4:0] rs2;
        logic       u2;
        logic [4:0] rd;
        logic       wb;
        logic       exr;
        logic       wbv;
        logic [4:0] wbrd;
        logic       redir;
        logic       e_issue;
        logic       e_stall;
        logic       e_kill;
        logic [31:0] e_busy;
    } vec_t;

    typedef struct {
        int          idx;
        logic        e_issue;
        logic        e_stall;
        logic        e_kill;
        logic [31:0] e_busy;
    } exp_t;

    vec_t tbl[$];
    exp_t sbq[$];

    function automatic logic [31:0] b(input int r);
        b = (r == 0) ? 32'h0 : (32'h1 << r);
    endfunction

    function automatic vec_t mk(
        input logic valid, input int rs1, input logic u1,
        input int rs2, input logic u2, input int rd, input logic wb,
        input logic exr, input logic wbv, input int wbrd,
        input logic redir, input logic ei, input logic es,
        input logic ek, input logic [31:0] eb
    );
        vec_t v;
        v.valid = valid; v.rs1 = 5'(rs1); v.u1 = u1;
        v.rs2 = 5'(rs2); v.u2 = u2; v.rd = 5'(rd); v.wb = wb;
        v.exr = exr; v.wbv = wbv; v.wbrd = 5'(wbrd); v.redir = redir;
        v.e_issue = ei; v.e_stall = es; v.e_kill = ek; v.e_busy = eb;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        id_valid_i = v.valid; id_rs1_i = v.rs1; id_rs2_i = v.rs2;
        id_rd_i = v.rd; id_rs1_used_i = v.u1; id_rs2_used_i = v.u2;
        id_wb_en_i = v.wb; ex_ready_i = v.exr; wb_valid_i = v.wbv;
        wb_rd_i = v.wbrd; redirect_i = v.redir;
    endtask

    task automatic apply(input vec_t v, input int i);
        exp_t e;
        @(posedge clk_i);
        #1;
        drive(v);
        e.idx = i; e.e_issue = v.e_issue; e.e_stall = v.e_stall;
        e.e_kill = v.e_kill; e.e_busy = v.e_busy;
        sbq.push_back(e);
        @(negedge clk_i);
        if (sbq.size() == 0) begin
            chk("queue_empty", 64'd1, 64'd0);
        end else begin
            e = sbq.pop_front();
            chk($sformatf("v%0d_issue", e.idx), 64'(issue_o), 64'(e.e_issue));
            chk($sformatf("v%0d_stall", e.idx), 64'(stall_o), 64'(e.e_stall));
            chk($sformatf("v%0d_kill", e.idx), 64'(kill_o), 64'(e.e_kill));
            chk($sformatf("v%0d_busy", e.idx), 64'(busy_regs_o), 64'(e.e_busy));
        end
    endtask

    function automatic vec_t idle(input logic wbv, input int wbrd,
                                  input logic [31:0] eb);
        return mk(0, 0, 0, 0, 0, 0, 0, 1, wbv, wbrd, 0, 0, 0, 0, eb);
    endfunction

    initial begin
        vec_t z;
        z = idle(0, 0, 0);
        drive(z);
        n_rst = 1'b0;
        id_valid_i = 1'b1;
        #1;
        chk("rst_issue", 64'(issue_o), 64'd0);
        chk("rst_stall", 64'(stall_o), 64'd0);
        chk("rst_kill", 64'(kill_o), 64'd0);
        chk("rst_busy", 64'(busy_regs_o), 64'd0);
        chk("rst_stall_cnt", 64'(stall_cycles_o), 64'd0);
        chk("rst_flush_cnt", 64'(flush_count_o), 64'd0);
        drive(z);
        repeat (2) @(negedge clk_i);
        n_rst = 1'b1;

        // back-to-back RAW on x5, release visible one cycle after wb
        tbl.push_back(mk(1, 1, 1, 0, 0, 5, 1, 1, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 5, 1, 0, 0, 6, 1, 1, 0, 0, 0, 0, 1, 0, b(5)));
        tbl.push_back(mk(1, 5, 1, 0, 0, 6, 1, 1, 1, 5, 0, 0, 1, 0, b(5)));
        tbl.push_back(mk(1, 5, 1, 0, 0, 6, 1, 1, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(idle(1, 6, b(6)));
        tbl.push_back(idle(0, 0, 0));
        // x0 never recorded; unused rs2 ignored
        tbl.push_back(mk(1, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 7, 0, 7, 1, 1, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 7, 0, 0, 1, 1, 0, 0, 0, 1, 0, 0, b(7)));
        tbl.push_back(idle(1, 7, b(7)));
        tbl.push_back(idle(0, 0, 0));
        // same-cycle set and clear of x3: set wins
        tbl.push_back(mk(1, 0, 0, 0, 0, 3, 1, 1, 1, 3, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 3, 1, 1, 1, 3, 0, 0, 1, 0, b(3)));
        tbl.push_back(mk(1, 0, 0, 0, 0, 3, 1, 1, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(idle(0, 0, b(3)));
        tbl.push_back(idle(1, 3, b(3)));
        tbl.push_back(idle(0, 0, 0));
        // WAW on x9 then 3 cycles of ex backpressure
        tbl.push_back(mk(1, 0, 0, 0, 0, 9, 1, 1, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 9, 1, 1, 0, 0, 0, 0, 1, 0, b(9)));
        tbl.push_back(mk(1, 0, 0, 0, 0, 9, 1, 1, 1, 9, 0, 0, 1, 0, b(9)));
        for (int k = 0; k < 3; k++) begin
            tbl.push_back(mk(1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0, 0, 1, 0, 0));
        end
        tbl.push_back(mk(1, 0, 0, 0, 0, 9, 1, 1, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(idle(1, 9, b(9)));
        tbl.push_back(idle(0, 0, 0));
        // redirect beats issue; second redirect in FLUSH ignored
        tbl.push_back(mk(1, 0, 0, 0, 0, 10, 1, 1, 0, 0, 1, 0, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 10, 1, 1, 0, 0, 1, 0, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 10, 1, 1, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(idle(1, 10, b(10)));
        tbl.push_back(idle(0, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], i);
        end
        chk("queue_drained", 64'(sbq.size()), 64'd0);

        // stalls: 2 RAW + 1 WAW + 2 WAW + 3 backpressure
        chk("stall_cycles", 64'(stall_cycles_o), 64'd8);
        chk("flush_count", 64'(flush_count_o), 64'd1);
        chk("sat_stall_cycles", 64'(s_stall_cnt), 64'd3);
        chk("sat_flush_count", 64'(s_flush_cnt), 64'd1);

        // async reset mid-flush with x5 and x10 pending
        apply(mk(1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0, 1, 0, 0, 0), 100);
        apply(mk(1, 0, 0, 0, 0, 10, 1, 1, 0, 0, 0, 1, 0, 0, b(5)), 101);
        apply(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 1, 32'h420), 102);
        @(posedge clk_i);
        #1;
        drive(mk(1, 1, 1, 2, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        #1;
        chk("flush_kill", 64'(kill_o), 64'd1);
        chk("flush_busy", 64'(busy_regs_o), 64'h420);
        n_rst = 1'b0;
        #1;
        chk("arst_issue", 64'(issue_o), 64'd0);
        chk("arst_stall", 64'(stall_o), 64'd0);
        chk("arst_kill", 64'(kill_o), 64'd0);
        chk("arst_busy", 64'(busy_regs_o), 64'd0);
        chk("arst_stall_cnt", 64'(stall_cycles_o), 64'd0);
        chk("arst_flush_cnt", 64'(flush_count_o), 64'd0);
        @(negedge clk_i);
        n_rst = 1'b1;
        #1;
        chk("post_rst_issue", 64'(issue_o), 64'd1);
        chk("post_rst_kill", 64'(kill_o), 64'd0);
        @(posedge clk_i);
        #1;
        drive(z);
        chk("post_rst_busy", 64'(busy_regs_o), 64'h2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
